// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the native memory interface (valid/ready, addr,
// wdata, wstrb, instr). The memory-side responder and the cache both import
// this package. The cache uses MEM_BYTES as its off-limit threshold.
// -----------------------------------------------------------------------------
package mem_if_pkg;

  // Responder FSM state encoding. The cache and debug tooling rely on these
  // fixed values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } mem_state_t;

  // Physical RAM size in bytes. Byte addresses at or above this are out of range.
  localparam int MEM_BYTES     = 'h10000;
  localparam int DEF_MEM_WORDS = MEM_BYTES / 4;

  // Default wait-state counts. Each must lie in the range 0..15.
  localparam int DEF_READ_LATENCY  = 4;
  localparam int DEF_WRITE_LATENCY = 2;

  // Read data returned for out-of-range addresses.
  localparam logic [31:0] DEF_OOR_RDATA = 32'h0000_0000;

  // Byte-enable width of a 32-bit word.
  localparam int STRB_W = 4;

  // Width of the wait-state counter, which covers latencies 0..15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_word_ram.sv
// -----------------------------------------------------------------------------
// mem_word_ram
// Synchronous single-port RAM of WORDS x 32 bits with per-byte write enables.
// The read is read-first: rdata shows the old word on the cycle after en=1.
// Ports:
//   clk    - clock
//   en     - access enable (read, and write on the lanes selected by we)
//   we     - per-byte write enables, lane i = bits 8i+7:8i
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data, updated only when en=1
// -----------------------------------------------------------------------------
module mem_word_ram
  import mem_if_pkg::*;
#(
  parameter int WORDS = DEF_MEM_WORDS,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [WORDS];

  // NOTE: the array and its output register have no reset. A reset would stop
  // the tools from mapping this onto block RAM. RAM contents survive a reset
  // of the responder.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (we[i]) begin
          // NOTE: sequential state takes non-blocking assignments only. The
          // read below therefore sees the pre-write word.
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_latency_responder.sv
// -----------------------------------------------------------------------------
// mem_latency_responder
// Word-addressed main-memory responder with programmable wait states. It
// accepts one request at a time. Before the single-cycle mem_ready pulse it
// inserts READ_LATENCY or WRITE_LATENCY wait cycles. After each response it
// inserts one GAP turnaround cycle. Addresses at or above MEM_WORDS*4 are out
// of range: writes to them are dropped, reads return OOR_RDATA, and oor_error
// is set.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   mem_valid     - request valid; dropping it during WAIT aborts the access
//   mem_instr     - instruction-fetch qualifier, statistics only (unused here)
//   mem_addr      - byte address, bits [1:0] ignored
//   mem_wdata     - write data
//   mem_wstrb     - byte enables; zero means read
//   mem_ready     - one-cycle response strobe
//   mem_rdata     - read data, valid while mem_ready=1, holds otherwise
//   access_count  - completed accesses, saturating
//   oor_error     - sticky out-of-range flag
// -----------------------------------------------------------------------------
module mem_latency_responder
  import mem_if_pkg::*;
#(
  parameter int          MEM_WORDS     = DEF_MEM_WORDS,
  parameter int          READ_LATENCY  = DEF_READ_LATENCY,
  parameter int          WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter logic [31:0] OOR_RDATA     = DEF_OOR_RDATA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [31:0]       access_count,
  output logic              oor_error
);

  localparam int              AW         = $clog2(MEM_WORDS);
  localparam logic [31:0]     ADDR_LIMIT = 32'(MEM_WORDS * 4);
  localparam logic [LAT_W-1:0] RD_LAT    = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0] WR_LAT    = LAT_W'(WRITE_LATENCY);

  mem_state_t         state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt;

  // Request fields registered at capture. Input changes during WAIT are ignored.
  logic [AW-1:0]      req_word;
  logic [31:0]        req_wdata;
  logic [STRB_W-1:0]  req_wstrb;
  logic               req_write;
  logic               req_oor;

  logic [31:0]        rdata_hold;

  // Decode of the live request, used only while IDLE.
  logic               in_write;
  logic               in_oor;
  logic [LAT_W-1:0]   in_lat;
  logic [AW-1:0]      in_word;

  // RAM port
  logic               ram_en;
  logic [STRB_W-1:0]  ram_we;
  logic [AW-1:0]      ram_addr;
  logic [31:0]        ram_rdata;
  logic [31:0]        rd_value;

  // The byte offset and the fetch qualifier play no part in the access.
  logic               unused_inputs;
  assign unused_inputs = ^{mem_instr, mem_addr[1:0]};

  assign in_write = |mem_wstrb;
  assign in_oor   = (mem_addr >= ADDR_LIMIT);
  assign in_lat   = in_write ? WR_LAT : RD_LAT;
  assign in_word  = mem_addr[AW+1:2];

  // Next state and RAM control.
  // NOTE: every signal written here is given a default first. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = req_word;

    case (state)
      ST_IDLE: if (mem_valid) state_nxt = (in_lat == '0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!mem_valid)                     state_nxt = ST_IDLE;
        else if (lat_cnt == LAT_W'(1))      state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // With zero latency the RESP cycle follows IDLE directly. The read then
    // has to be issued from the live address, before the capture registers
    // are loaded.
    if (state == ST_IDLE) ram_addr = in_word;

    // The RAM read is registered, so the read is issued on the cycle that
    // enters RESP. The data is then ready while mem_ready is high.
    if (state_nxt == ST_RESP) ram_en = 1'b1;

    // The write is committed at the end of RESP. An asynchronous reset moves
    // the FSM out of RESP at once, so no write follows a reset.
    if (state == ST_RESP && req_write && !req_oor) begin
      ram_en = 1'b1;
      ram_we = req_wstrb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      req_word     <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      req_write    <= 1'b0;
      req_oor      <= 1'b0;
      rdata_hold   <= '0;
      access_count <= '0;
      oor_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            req_word  <= in_word;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
            req_write <= in_write;
            req_oor   <= in_oor;
            lat_cnt   <= in_lat;
          end
        end
        ST_WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
        ST_RESP: begin
          if (!req_write)           rdata_hold   <= rd_value;
          if (access_count != '1)   access_count <= access_count + 32'd1;
          if (req_oor)              oor_error    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_value  = req_oor ? OOR_RDATA : ram_rdata;
  assign mem_ready = (state == ST_RESP);
  assign mem_rdata = (state == ST_RESP && !req_write) ? rd_value : rdata_hold;

  mem_word_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_latency_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_latency_responder
// Directed stimulus. The driver pushes the expected response, meaning the cycle
// of the mem_ready pulse and the mem_rdata value, into a scoreboard queue. A
// monitor pops an entry and compares it on every mem_ready pulse. Register
// state (access_count, oor_error, reset values) is checked directly.
// -----------------------------------------------------------------------------
module tb_mem_latency_responder;
  import mem_if_pkg::*;

  localparam int RL = 4;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] access_count;
  logic        oor_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_rd = '0;   // model of the value mem_rdata holds

  mem_latency_responder #(
    .MEM_WORDS     (16384),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL),
    .OOR_RDATA     (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .access_count (access_count),
    .oor_error    (oor_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && mem_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got a pulse expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ready_cycle", 32'(cyc), 32'(mon_e.due));
        check("rdata", mem_rdata, mon_e.rdata);
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request. off=0 when called in an IDLE cycle. off=1 when called in
  // the GAP cycle that follows a response while mem_valid is held high. The
  // task returns #1 into the GAP cycle after the response.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] rd_exp, input bit keep, input int off);
    exp_t e;
    bit   seen;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = (s == 4'b0);
    mem_valid = 1'b1;
    e.due = cyc + off + 1 + ((s == 4'b0) ? RL : WL);
    if (s == 4'b0) begin
      e.rdata = rd_exp;
      last_rd = rd_exp;
    end else begin
      e.rdata = last_rd;
    end
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mem_ready;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no pulse for addr %h expected one", a);
    end
    @(posedge clk);
    #1;
    if (!keep) mem_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Preload through the interface. RAM contents survive the reset below.
    idle(); req(32'h0000_0000, 32'h5A5A_5A5A, 4'hF, '0, 1'b0, 0);
    idle(); req(32'h0000_0010, 32'hCAFE_F00D, 4'hF, '0, 1'b0, 0);
    idle(); req(32'h0000_0020, 32'hAAAA_AAAA, 4'hF, '0, 1'b0, 0);

    reset = 1'b1;
    last_rd = '0;
    @(negedge clk);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_count", access_count, 32'd0);
    check("rst_oor", {31'b0, oor_error}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Read with latency 4: pulse in T+5.
    idle(); req(32'h0000_0010, '0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);
    @(negedge clk); check("count_after_read", access_count, 32'd1);

    // Partial-strobe write, then read back.
    idle(); req(32'h0000_0020, 32'h1122_3344, 4'b0101, '0, 1'b0, 0);
    idle(); req(32'h0000_0020, '0, 4'h0, 32'hAA22_AA44, 1'b0, 0);

    // Burst of writes with mem_valid held high across the GAP cycles.
    idle();
    req(32'h0000_0100, 32'hB0B0_0001, 4'hF, '0, 1'b1, 0);
    req(32'h0000_0104, 32'hB0B0_0002, 4'hF, '0, 1'b1, 1);
    req(32'h0000_0108, 32'hB0B0_0003, 4'hF, '0, 1'b1, 1);
    req(32'h0000_010C, 32'hB0B0_0004, 4'hF, '0, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      req(32'h0000_0100 + 32'(4 * i), '0, 4'h0, 32'hB0B0_0001 + 32'(i), 1'b0, 0);
    end
    @(negedge clk);
    check("count_after_burst", access_count, 32'd11);
    check("oor_still_clear", {31'b0, oor_error}, 32'd0);

    // Out-of-range read and write. The dropped write would alias word 0.
    idle(); req(32'h0001_0000, '0, 4'h0, 32'h0000_0000, 1'b0, 0);
    @(negedge clk); check("oor_set", {31'b0, oor_error}, 32'd1);
    idle(); req(32'h0002_0000, 32'hFFFF_FFFF, 4'hF, '0, 1'b0, 0);
    idle(); req(32'h0000_0000, '0, 4'h0, 32'h5A5A_5A5A, 1'b0, 0);
    @(negedge clk); check("count_after_oor", access_count, 32'd14);

    // mem_valid dropped in the second WAIT cycle of a write.
    idle();
    mem_addr = 32'h0000_0020; mem_wdata = 32'h0; mem_wstrb = 4'hF; mem_valid = 1'b1;
    idle();
    idle();
    mem_valid = 1'b0;
    repeat (6) idle();
    @(negedge clk); check("count_after_abort", access_count, 32'd14);
    idle(); req(32'h0000_0020, '0, 4'h0, 32'hAA22_AA44, 1'b0, 0);

    // reset asserted during WAIT of a write.
    idle();
    mem_addr = 32'h0000_0010; mem_wdata = 32'h0; mem_wstrb = 4'hF; mem_valid = 1'b1;
    idle();
    reset = 1'b1;
    mem_valid = 1'b0;
    last_rd = '0;
    @(negedge clk);
    check("midwait_rst_ready", {31'b0, mem_ready}, 32'd0);
    check("midwait_rst_rdata", mem_rdata, 32'd0);
    check("midwait_rst_count", access_count, 32'd0);
    check("midwait_rst_oor", {31'b0, oor_error}, 32'd0);
    repeat (3) idle();
    reset = 1'b0;
    idle(); req(32'h0000_0010, '0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);
    @(negedge clk); check("count_after_reset", access_count, 32'd1);

    repeat (3) idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
